// File: rtl/scu_pkg.sv
// Shared encodings and default sizes for the pipeline execute stage.
package scu_pkg;

  localparam int WIDTH_DEF = 32;  // datapath width
  localparam int RA_W_DEF  = 6;   // register-address width (64 registers)

  // ALU operation codes; codes 1xx are reserved and behave as PASS.
  typedef enum logic [2:0] {
    ALU_PASS = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_NEG  = 3'b011
  } alu_op_e;

  // Write-back source select carried down to MEM/WB.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC   = 2'b10,
    WB_NONE = 2'b11
  } wb_sel_e;

  // True for the ALU ops that produce condition flags.
  function automatic logic op_sets_flags(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_NEG);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: PASS/ADD/SUB/NEG, modulo 2^WIDTH, with zero/negative outputs.
module alu
  import scu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n
);

  // Select the operation; reserved codes fall through to PASS.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    result = a;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_NEG: result = '0 - a;
      default: result = a;
    endcase
  end

  assign z = (result == '0);
  assign n = result[WIDTH-1];

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, Z/N flags, branch/jump resolution and the EX/MEM register.
module ex_stage
  import scu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RA_W  = RA_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             valid_ex,
  input  logic [2:0]       aluOp_ex,
  input  logic             aluSrc_ex,
  input  logic             memRead_ex,
  input  logic             memWrite_ex,
  input  logic             regWrt_ex,
  input  logic             jumpMem_ex,
  input  logic [1:0]       writeBackControl_ex,
  input  logic             branchZero_ex,
  input  logic             branchNeg_ex,
  input  logic             jump_ex,
  input  logic [WIDTH-1:0] xrs_ex,
  input  logic [WIDTH-1:0] xrt_ex,
  input  logic [WIDTH-1:0] y_ex,
  input  logic [WIDTH-1:0] pc_plus_y_ex,
  input  logic [RA_W-1:0]  rd_ex,
  output logic [WIDTH-1:0] aluResult_mem,
  output logic [WIDTH-1:0] storeData_mem,
  output logic [WIDTH-1:0] pc_plus_y_mem,
  output logic [RA_W-1:0]  rd_mem,
  output logic [1:0]       writeBackControl_mem,
  output logic             memRead_mem,
  output logic             memWrite_mem,
  output logic             regWrt_mem,
  output logic             jumpMem_mem,
  output logic             valid_mem,
  output logic             flagZ,
  output logic             flagN,
  output logic             redirect,
  output logic [WIDTH-1:0] pcTarget
);

  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_z;
  logic             alu_n;
  logic             advance;
  logic             flag_update;
  logic             take;

  assign operand_b = aluSrc_ex ? y_ex : xrt_ex;
  assign advance   = ~stall;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (xrs_ex),
    .b      (operand_b),
    .op     (aluOp_ex),
    .result (alu_result),
    .z      (alu_z),
    .n      (alu_n)
  );

  // Only real, non-stalled arithmetic ops change the condition flags.
  assign flag_update = valid_ex & advance & op_sets_flags(aluOp_ex);

  // Flag registers; branches read these, i.e. the result of the previous ALU op.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flagZ <= 1'b0;
      flagN <= 1'b0;
    end else if (flag_update) begin
      // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
      flagZ <= alu_z;
      flagN <= alu_n;
    end
  end

  // Branch resolution against registered flags; the target is always xrs.
  assign take     = jump_ex | (branchZero_ex & flagZ) | (branchNeg_ex & flagN);
  assign redirect = valid_ex & advance & take;
  assign pcTarget = xrs_ex;

  // EX/MEM boundary: data loads whenever not stalled, side-effect controls are gated by valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aluResult_mem        <= '0;
      storeData_mem        <= '0;
      pc_plus_y_mem        <= '0;
      rd_mem               <= '0;
      writeBackControl_mem <= '0;
      memRead_mem          <= 1'b0;
      memWrite_mem         <= 1'b0;
      regWrt_mem           <= 1'b0;
      jumpMem_mem          <= 1'b0;
      valid_mem            <= 1'b0;
    end else if (advance) begin
      aluResult_mem        <= alu_result;
      storeData_mem        <= xrt_ex;
      pc_plus_y_mem        <= pc_plus_y_ex;
      rd_mem               <= rd_ex;
      writeBackControl_mem <= writeBackControl_ex;
      memRead_mem          <= memRead_ex  & valid_ex;
      memWrite_mem         <= memWrite_ex & valid_ex;
      regWrt_mem           <= regWrt_ex   & valid_ex;
      jumpMem_mem          <= jumpMem_ex  & valid_ex;
      valid_mem            <= valid_ex;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, stall/reset sequences, random vs model.
module tb_ex_stage;
  import scu_pkg::*;

  localparam int W  = 32;
  localparam int RW = 6;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          stall;
  logic          valid_ex;
  logic [2:0]    aluOp_ex;
  logic          aluSrc_ex, memRead_ex, memWrite_ex, regWrt_ex, jumpMem_ex;
  logic [1:0]    writeBackControl_ex;
  logic          branchZero_ex, branchNeg_ex, jump_ex;
  logic [W-1:0]  xrs_ex, xrt_ex, y_ex, pc_plus_y_ex;
  logic [RW-1:0] rd_ex;
  logic [W-1:0]  aluResult_mem, storeData_mem, pc_plus_y_mem;
  logic [RW-1:0] rd_mem;
  logic [1:0]    writeBackControl_mem;
  logic          memRead_mem, memWrite_mem, regWrt_mem, jumpMem_mem, valid_mem;
  logic          flagZ, flagN, redirect;
  logic [W-1:0]  pcTarget;

  ex_stage #(.WIDTH(W), .RA_W(RW)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .valid_ex(valid_ex),
    .aluOp_ex(aluOp_ex), .aluSrc_ex(aluSrc_ex), .memRead_ex(memRead_ex),
    .memWrite_ex(memWrite_ex), .regWrt_ex(regWrt_ex), .jumpMem_ex(jumpMem_ex),
    .writeBackControl_ex(writeBackControl_ex), .branchZero_ex(branchZero_ex),
    .branchNeg_ex(branchNeg_ex), .jump_ex(jump_ex), .xrs_ex(xrs_ex), .xrt_ex(xrt_ex),
    .y_ex(y_ex), .pc_plus_y_ex(pc_plus_y_ex), .rd_ex(rd_ex),
    .aluResult_mem(aluResult_mem), .storeData_mem(storeData_mem),
    .pc_plus_y_mem(pc_plus_y_mem), .rd_mem(rd_mem),
    .writeBackControl_mem(writeBackControl_mem), .memRead_mem(memRead_mem),
    .memWrite_mem(memWrite_mem), .regWrt_mem(regWrt_mem), .jumpMem_mem(jumpMem_mem),
    .valid_mem(valid_mem), .flagZ(flagZ), .flagN(flagN), .redirect(redirect),
    .pcTarget(pcTarget)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          valid;
    logic [2:0]    op;
    logic          src, mr, mw, rw, jm;
    logic [1:0]    wb;
    logic          bz, bn, j;
    logic [W-1:0]  xrs, xrt, y, pcy;
    logic [RW-1:0] rd;
  } ex_in_t;

  typedef struct {
    ex_in_t       in;
    logic         redir;
    logic [W-1:0] res, st;
    logic         z, n, mw, rw, jm;
  } vec_t;

  // Expected EX/MEM contents and flags
  typedef struct packed {
    logic [W-1:0]  res, st, pcy;
    logic [RW-1:0] rd;
    logic [1:0]    wb;
    logic          mr, mw, rw, jm, valid;
  } mem_t;

  mem_t m_mem;
  logic m_z, m_n;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic ex_in_t base(input logic [2:0] op, input logic [W-1:0] xrs);
    ex_in_t i;
    i       = '0;
    i.valid = 1'b1;
    i.op    = op;
    i.xrs   = xrs;
    i.pcy   = xrs ^ 32'h0000_1000;
    i.rd    = xrs[RW-1:0];
    return i;
  endfunction

  task automatic drive(input ex_in_t i, input logic stl);
    stall = stl; valid_ex = i.valid; aluOp_ex = i.op; aluSrc_ex = i.src;
    memRead_ex = i.mr; memWrite_ex = i.mw; regWrt_ex = i.rw; jumpMem_ex = i.jm;
    writeBackControl_ex = i.wb; branchZero_ex = i.bz; branchNeg_ex = i.bn; jump_ex = i.j;
    xrs_ex = i.xrs; xrt_ex = i.xrt; y_ex = i.y; pc_plus_y_ex = i.pcy; rd_ex = i.rd;
  endtask

  // Arithmetic from the operation definitions, modulo 2^32.
  function automatic logic [W-1:0] ref_alu(input ex_in_t i);
    longint unsigned a, b;
    a = i.xrs;
    b = i.src ? i.y : i.xrt;
    case (i.op)
      3'd1:    return W'((a + b) % 64'h1_0000_0000);
      3'd2:    return W'((a + 64'h1_0000_0000 - b) % 64'h1_0000_0000);
      3'd3:    return W'((64'h1_0000_0000 - a) % 64'h1_0000_0000);
      default: return W'(a);
    endcase
  endfunction

  function automatic logic ref_redirect(input ex_in_t i, input logic stl);
    return i.valid && !stl && (i.j || (i.bz && m_z) || (i.bn && m_n));
  endfunction

  task automatic model_reset();
    m_mem = '0; m_z = 1'b0; m_n = 1'b0;
  endtask

  task automatic model_edge(input ex_in_t i, input logic stl);
    logic [W-1:0] r;
    if (!stl) begin
      r = ref_alu(i);
      m_mem.res = r;      m_mem.st = i.xrt;   m_mem.pcy = i.pcy;
      m_mem.rd  = i.rd;   m_mem.wb = i.wb;    m_mem.valid = i.valid;
      m_mem.mr  = i.valid && i.mr;  m_mem.mw = i.valid && i.mw;
      m_mem.rw  = i.valid && i.rw;  m_mem.jm = i.valid && i.jm;
      if (i.valid && i.op >= 3'd1 && i.op <= 3'd3) begin
        m_z = (r == 0);
        m_n = (r >= 32'h8000_0000);
      end
    end
  endtask

  function automatic mem_t dut_mem();
    mem_t d;
    d.res = aluResult_mem; d.st = storeData_mem; d.pcy = pc_plus_y_mem; d.rd = rd_mem;
    d.wb = writeBackControl_mem; d.mr = memRead_mem; d.mw = memWrite_mem;
    d.rw = regWrt_mem; d.jm = jumpMem_mem; d.valid = valid_mem;
    return d;
  endfunction

  // One cycle against the model: redirect before the edge, EX/MEM and flags after it.
  task automatic model_cycle(input ex_in_t i, input logic stl, input string tag);
    logic er;
    drive(i, stl);
    er = ref_redirect(i, stl);
    #1;
    check({tag, " redirect"}, redirect, er);
    if (er) check({tag, " pcTarget"}, pcTarget, i.xrs);
    @(posedge clock);
    model_edge(i, stl);
    @(negedge clock);
    check({tag, " exmem"}, dut_mem(), m_mem);
    check({tag, " flags"}, {flagZ, flagN}, {m_z, m_n});
  endtask

  function automatic ex_in_t rand_in();
    ex_in_t i;
    i       = ex_in_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    i.valid = ($urandom_range(0, 4) != 0);
    if ($urandom_range(0, 3) == 0) i.xrs = $urandom_range(0, 2);
    if ($urandom_range(0, 3) == 0) begin
      i.src = 1'b0;
      i.xrt = ($urandom_range(0, 1) != 0) ? i.xrs : (32'h0 - i.xrs);
    end
    return i;
  endfunction

  vec_t vecs[13];

  initial begin
    ex_in_t t;
    // Directed vectors, applied back to back from reset.
    t = base(3'd1, 32'd5); t.xrt = 32'hFFFF_FFFB; t.rw = 1'b1;
    vecs[0]  = '{t, 1'b0, 32'h0, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    t = base(3'd0, 32'h80); t.bz = 1'b1;
    vecs[1]  = '{t, 1'b1, 32'h80, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t = base(3'd2, 32'd3); t.y = 32'd7; t.src = 1'b1; t.xrt = 32'h11; t.rw = 1'b1;
    vecs[2]  = '{t, 1'b0, 32'hFFFF_FFFC, 32'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    t = base(3'd0, 32'h40); t.bn = 1'b1;
    vecs[3]  = '{t, 1'b1, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    t = base(3'd0, 32'h44); t.bz = 1'b1;
    vecs[4]  = '{t, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    t = base(3'd1, 32'h0); t.valid = 1'b0; t.mw = 1'b1; t.rw = 1'b1; t.j = 1'b1;
    vecs[5]  = '{t, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    t = base(3'd0, 32'h100); t.xrt = 32'hAB; t.mw = 1'b1;
    vecs[6]  = '{t, 1'b0, 32'h100, 32'hAB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    t = base(3'd0, 32'h200); t.jm = 1'b1;
    vecs[7]  = '{t, 1'b0, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    t = base(3'd3, 32'h0);
    vecs[8]  = '{t, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t = base(3'd6, 32'h7FFF_FFFF); t.xrt = 32'd5;
    vecs[9]  = '{t, 1'b0, 32'h7FFF_FFFF, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t = base(3'd1, 32'h7FFF_FFFF); t.y = 32'd1; t.src = 1'b1;
    vecs[10] = '{t, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    t = base(3'd1, 32'hFFFF_FFFF); t.xrt = 32'd1;
    vecs[11] = '{t, 1'b0, 32'h0, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t = base(3'd0, 32'h1234); t.j = 1'b1;
    vecs[12] = '{t, 1'b1, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset
    reset_n = 1'b0;
    drive('0, 1'b0);
    model_reset();
    repeat (2) @(negedge clock);
    check("reset exmem", dut_mem(), '0);
    check("reset flags", {flagZ, flagN}, 2'b00);
    check("reset redirect", redirect, 1'b0);
    reset_n = 1'b1;

    // Directed table
    foreach (vecs[k]) begin
      drive(vecs[k].in, 1'b0);
      #1;
      check($sformatf("vec%0d redirect", k), redirect, vecs[k].redir);
      if (vecs[k].redir) check($sformatf("vec%0d pcTarget", k), pcTarget, vecs[k].in.xrs);
      @(posedge clock);
      model_edge(vecs[k].in, 1'b0);
      @(negedge clock);
      check($sformatf("vec%0d aluResult", k), aluResult_mem, vecs[k].res);
      check($sformatf("vec%0d storeData", k), storeData_mem, vecs[k].st);
      check($sformatf("vec%0d flags", k), {flagZ, flagN}, {vecs[k].z, vecs[k].n});
      check($sformatf("vec%0d ctrl", k), {memWrite_mem, regWrt_mem, jumpMem_mem, valid_mem},
            {vecs[k].mw, vecs[k].rw, vecs[k].jm, vecs[k].in.valid});
    end

    // BRZ held under stall with flagZ = 1: no redirect, outputs frozen; then released.
    t = base(3'd0, 32'h300); t.bz = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(t, 1'b1);
      #1;
      check("stall redirect", redirect, 1'b0);
      @(posedge clock);
      @(negedge clock);
      check("stall aluResult held", aluResult_mem, 32'h1234);
      check("stall flags held", {flagZ, flagN}, 2'b10);
      check("stall valid held", valid_mem, 1'b1);
    end
    drive(t, 1'b0);
    #1;
    check("unstall redirect", redirect, 1'b1);
    check("unstall pcTarget", pcTarget, 32'h300);
    @(posedge clock);
    model_edge(t, 1'b0);
    @(negedge clock);
    check("unstall aluResult", aluResult_mem, 32'h300);

    // Reset asserted mid-stall, in the middle of a cycle.
    t = base(3'd1, 32'h5); t.xrt = 32'h9; t.mw = 1'b1;
    drive(t, 1'b1);
    @(posedge clock);
    #2;
    reset_n  = 1'b0;
    valid_ex = 1'b0;
    #1;
    check("midreset exmem", dut_mem(), '0);
    check("midreset flags", {flagZ, flagN}, 2'b00);
    check("midreset redirect", redirect, 1'b0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;

    // Random stimulus against the reference model.
    for (int c = 0; c < 400; c++) begin
      model_cycle(rand_in(), ($urandom_range(0, 3) == 0), $sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
